// File: rtl/cycle_meter.sv
// -----------------------------------------------------------------------------
// cycle_meter
//   Measures how many clock cycles a tagged token spends between acceptance and
//   a stop event, then presents {tag, cycle count} on a valid/ready port.
//   This is the inverse of a cycle-delay stage: it turns a delay back into a
//   cycle count. It is used to time request->response paths in benches and
//   perf monitors.
//
//   Optional feature macro: CYCLE_METER_TIMEOUT_EN
//     When defined, an interval that reaches timeout_p cycles without stop_i
//     ends on its own with timeout_o=1. When undefined there is no timeout
//     logic and timeout_o is tied to 0.
//
// Parameters
//   width_p         tag width (data_i / data_o)
//   cycles_width_p  measured-count width; the count saturates at all-ones
//   timeout_p       timeout threshold, 1 <= timeout_p < 2^cycles_width_p
//
// Ports
//   clk_i      in   clock, all logic on posedge
//   reset_n_i  in   synchronous reset, active-low
//   v_i        in   start token valid
//   data_i     in   start token tag
//   yumi_o     out  start token consumed this cycle (v_i while IDLE)
//   stop_i     in   end-of-interval event, only looked at while counting
//   v_o        out  result valid
//   data_o     out  tag captured at acceptance
//   cycles_o   out  measured cycles
//   sat_o      out  count saturated during the interval
//   timeout_o  out  interval ended by timeout
//   ready_i    in   downstream takes the result when v_o & ready_i
// -----------------------------------------------------------------------------
module cycle_meter #(
   parameter int width_p        = 8,
   parameter int cycles_width_p = 16,
   parameter int timeout_p      = 1000
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      v_i,
   input  logic [width_p-1:0]        data_i,
   output logic                      yumi_o,
   input  logic                      stop_i,
   output logic                      v_o,
   output logic [width_p-1:0]        data_o,
   output logic [cycles_width_p-1:0] cycles_o,
   output logic                      sat_o,
   output logic                      timeout_o,
   input  logic                      ready_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [cycles_width_p-1:0] r_count;
   logic [cycles_width_p-1:0] w_count_next;
   logic [cycles_width_p-1:0] r_cycles;
   logic [cycles_width_p-1:0] w_cycles_next;
   logic [width_p-1:0]        r_data;
   logic [width_p-1:0]        w_data_next;
   logic                      r_sat;
   logic                      w_sat_next;
   logic                      w_count_max;
   logic                      w_timeout_hit;

   assign w_count_max = &r_count;

`ifdef CYCLE_METER_TIMEOUT_EN
   localparam logic [cycles_width_p-1:0] TIMEOUT_LIMIT = cycles_width_p'(timeout_p);

   logic r_timeout;
   logic w_timeout_next;

   // A stop in the same cycle takes priority, so the hit is qualified by !stop_i
   // both here and in the main next-state logic.
   assign w_timeout_hit = (r_count == TIMEOUT_LIMIT);

   always_comb begin
      w_timeout_next = r_timeout;
      if (r_state == ST_IDLE && v_i) begin
         w_timeout_next = 1'b0;
      end else if (r_state == ST_COUNT && !stop_i && w_timeout_hit) begin
         w_timeout_next = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_next;
      end
   end

   assign timeout_o = r_timeout;
`else
   // Keeps the threshold referenced in builds without the timeout feature.
   localparam int unused_timeout_p = timeout_p;

   assign w_timeout_hit = 1'b0;
   assign timeout_o     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and datapath next values
   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_cycles_next = r_cycles;
      w_data_next   = r_data;
      w_sat_next    = r_sat;

      case (r_state)
         ST_IDLE: begin
            // stop_i is deliberately ignored here, including the accept cycle.
            if (v_i) begin
               w_data_next  = data_i;
               w_count_next = cycles_width_p'(1);
               w_sat_next   = 1'b0;
               w_state_next = ST_COUNT;
            end
         end

         ST_COUNT: begin
            if (stop_i) begin
               w_cycles_next = r_count;
               w_state_next  = ST_DONE;
            end else if (w_timeout_hit) begin
               // r_count equals the threshold here, so it is the reported value.
               w_cycles_next = r_count;
               w_state_next  = ST_DONE;
            end else if (w_count_max) begin
               // Hold at all-ones; the lost increment is remembered in sat.
               w_sat_next = 1'b1;
            end else begin
               w_count_next = r_count + cycles_width_p'(1);
            end
         end

         ST_DONE: begin
            if (ready_i) begin
               w_state_next = ST_IDLE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_count  <= '0;
         r_cycles <= '0;
         r_data   <= '0;
         r_sat    <= 1'b0;
      end else begin
         r_count  <= w_count_next;
         r_cycles <= w_cycles_next;
         r_data   <= w_data_next;
         r_sat    <= w_sat_next;
      end
   end

   assign yumi_o   = v_i && (r_state == ST_IDLE);
   assign v_o      = (r_state == ST_DONE);
   assign data_o   = r_data;
   assign cycles_o = r_cycles;
   assign sat_o    = r_sat;

endmodule

// File: tb/tb_cycle_meter.sv
// -----------------------------------------------------------------------------
// tb_cycle_meter
//   Two instances share one stimulus stream: a full-width meter (16-bit count)
//   and a narrow one (4-bit count) that saturates at 15. Expected results are
//   queued per instance when a token is accepted; monitors pop and compare on
//   every cycle v_o is high, popping on the handshake.
// -----------------------------------------------------------------------------
module tb_cycle_meter;

   localparam int W   = 8;
   localparam int CW  = 16;
   localparam int CWS = 4;
   localparam int TO  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          v_i;
   logic [W-1:0]  data_i;
   logic          stop_i;
   logic          ready_i;

   logic          yumi_a, v_a, sat_a, to_a;
   logic [W-1:0]  data_a;
   logic [CW-1:0] cycles_a;

   logic           yumi_b, v_b, sat_b, to_b;
   logic [W-1:0]   data_b;
   logic [CWS-1:0] cycles_b;

   cycle_meter #(.width_p(W), .cycles_width_p(CW), .timeout_p(TO)) dut_a (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .v_i       (v_i),
      .data_i    (data_i),
      .yumi_o    (yumi_a),
      .stop_i    (stop_i),
      .v_o       (v_a),
      .data_o    (data_a),
      .cycles_o  (cycles_a),
      .sat_o     (sat_a),
      .timeout_o (to_a),
      .ready_i   (ready_i)
   );

   cycle_meter #(.width_p(W), .cycles_width_p(CWS), .timeout_p(TO)) dut_b (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .v_i       (v_i),
      .data_i    (data_i),
      .yumi_o    (yumi_b),
      .stop_i    (stop_i),
      .v_o       (v_b),
      .data_o    (data_b),
      .cycles_o  (cycles_b),
      .sat_o     (sat_b),
      .timeout_o (to_b),
      .ready_i   (ready_i)
   );

   typedef struct packed {
      logic [W-1:0]  tag;
      logic [CW-1:0] cycles;
      logic          sat;
      logic          to;
   } res_t;

   res_t q_a[$];
   res_t q_b[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // n = edges from accept to the edge that samples stop_i; a huge n means no stop.
   function automatic res_t model(input logic [W-1:0] tag, input int n, input int cw);
      res_t r;
      int   cap;
      cap   = (1 << cw) - 1;
      r.tag = tag;
      r.to  = 1'b0;
`ifdef CYCLE_METER_TIMEOUT_EN
      if (n > TO) begin
         r.cycles = CW'(TO);
         r.sat    = 1'b0;
         r.to     = 1'b1;
         return r;
      end
`endif
      r.cycles = CW'((n > cap) ? cap : n);
      r.sat    = (n > cap);
      return r;
   endfunction

   // Monitors
   always @(negedge clk) begin
      res_t e;
      if (v_a) begin
         if (q_a.size() == 0) begin
            check("a_v_o_without_token", 32'(v_a), 32'd0);
         end else begin
            e = q_a[0];
            check("a_data_o",    32'(data_a),   32'(e.tag));
            check("a_cycles_o",  32'(cycles_a), 32'(e.cycles));
            check("a_sat_o",     32'(sat_a),    32'(e.sat));
            check("a_timeout_o", 32'(to_a),     32'(e.to));
            check("a_yumi_in_done", 32'(yumi_a), 32'd0);
            if (ready_i) void'(q_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      res_t e;
      if (v_b) begin
         if (q_b.size() == 0) begin
            check("b_v_o_without_token", 32'(v_b), 32'd0);
         end else begin
            e = q_b[0];
            check("b_data_o",    32'(data_b),   32'(e.tag));
            check("b_cycles_o",  32'(cycles_b), 32'(e.cycles));
            check("b_sat_o",     32'(sat_b),    32'(e.sat));
            check("b_timeout_o", 32'(to_b),     32'(e.to));
            if (ready_i) void'(q_b.pop_front());
         end
      end
   end

   // One measured interval. stop_en=0 waits for a timeout instead of stopping.
   // hold>0 keeps ready_i low (with v_i high) for that many DONE cycles.
   task automatic measure(input logic [W-1:0] tag, input int n, input bit stop_en,
                          input int hold, input bit stop_at_accept);
      @(posedge clk); #1;
      v_i     = 1'b1;
      data_i  = tag;
      ready_i = (hold == 0);
      stop_i  = stop_at_accept;
      $display("[TB] txn tag=%02h n=%0d stop=%0d hold=%0d stop_at_accept=%0d",
               tag, n, stop_en, hold, stop_at_accept);
      @(negedge clk);
      check("yumi_o_accept_a", 32'(yumi_a), 32'd1);
      check("yumi_o_accept_b", 32'(yumi_b), 32'd1);
      q_a.push_back(model(tag, stop_en ? n : 100000, CW));
      q_b.push_back(model(tag, stop_en ? n : 100000, CWS));
      @(posedge clk); #1;
      v_i    = 1'b0;
      stop_i = 1'b0;
      if (stop_en) begin
         repeat (n - 1) @(posedge clk);
         #1;
         stop_i = 1'b1;
         @(posedge clk); #1;
         stop_i = 1'b0;
      end else begin
         for (int k = 0; k < 40 && !v_a; k++) begin
            @(posedge clk); #1;
         end
         check("timeout_reached", 32'(v_a), 32'd1);
      end
      if (hold > 0) begin
         v_i = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            check("yumi_o_done_a", 32'(yumi_a), 32'd0);
            check("yumi_o_done_b", 32'(yumi_b), 32'd0);
         end
         @(posedge clk); #1;
         ready_i = 1'b1;
         @(posedge clk); #1;
         @(negedge clk);
         check("yumi_o_after_handshake", 32'(yumi_a), 32'd1);
         check("v_o_after_handshake",    32'(v_a),    32'd0);
         #1;
         v_i = 1'b0;
      end else begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      v_i     = 1'b0;
      data_i  = '0;
      stop_i  = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_v_o",       32'(v_a),      32'd0);
      check("reset_yumi_o",    32'(yumi_a),   32'd0);
      check("reset_data_o",    32'(data_a),   32'd0);
      check("reset_cycles_o",  32'(cycles_a), 32'd0);
      check("reset_sat_o",     32'(sat_a),    32'd0);
      check("reset_timeout_o", 32'(to_a),     32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Basic interval and minimum latency
      measure(8'hA5, 5, 1'b1, 0, 1'b0);
      measure(8'h11, 1, 1'b1, 0, 1'b0);

      // stop_i while idle must not produce anything
      @(posedge clk); #1;
      stop_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      stop_i = 1'b0;
      @(negedge clk);
      check("idle_stop_no_v_o", 32'(v_a), 32'd0);

      // stop_i high in the accept cycle is ignored
      measure(8'h22, 3, 1'b1, 0, 1'b1);

      // Saturation boundaries on the narrow instance
      measure(8'hC3, 15, 1'b1, 0, 1'b0);
      measure(8'h0F, 16, 1'b1, 0, 1'b0);
      measure(8'h5A, 20, 1'b1, 0, 1'b0);

      // Backpressure in DONE with a new token waiting
      measure(8'h66, 4, 1'b1, 3, 1'b0);

      // Reset at count=3 discards the token
      @(posedge clk); #1;
      v_i    = 1'b1;
      data_i = 8'h3C;
      $display("[TB] txn tag=3c reset at count=3");
      @(posedge clk); #1;
      v_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      v_i     = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("midreset_v_o",       32'(v_a),      32'd0);
      check("midreset_data_o",    32'(data_a),   32'd0);
      check("midreset_cycles_o",  32'(cycles_a), 32'd0);
      check("midreset_sat_o",     32'(sat_a),    32'd0);
      check("midreset_timeout_o", 32'(to_a),     32'd0);
      check("midreset_yumi_o",    32'(yumi_a),   32'd1);
      #1;
      v_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;

`ifdef CYCLE_METER_TIMEOUT_EN
      measure(8'h77, 0, 1'b0, 0, 1'b0);
      measure(8'h88, 8, 1'b1, 0, 1'b0);
      measure(8'h99, 7, 1'b1, 0, 1'b0);
`endif

      measure(8'hE1, 2, 1'b1, 0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queue_a_drained", 32'(q_a.size()), 32'd0);
      check("queue_b_drained", 32'(q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
